// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/stall controller with memory-wait FSM and perf counters
module pipe_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_Rd_i,
    input  logic [4:0]  IFID_Rs1_i,
    input  logic [4:0]  IFID_Rs2_i,
    input  logic        Branch_taken_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ack_i,
    input  logic        cnt_clr_i,
    output logic        PC_Write_o,
    output logic        IFID_Write_o,
    output logic        IFID_Flush_o,
    output logic        IDEX_Bubble_o,
    output logic        mem_stall_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] hazard_cnt_o
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       flush_pending;
    logic       load_use;

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (dmem_req_i && !dmem_ack_i) state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_ack_i) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    // A hit (req and ack together) never stalls; the ack cycle of a miss does not stall either.
    assign mem_stall_o = rst_i &&
                         (((state == RUN) && dmem_req_i && !dmem_ack_i) ||
                          ((state == MEM_WAIT) && !dmem_ack_i));

    assign load_use = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                      ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));

    always_comb begin
        PC_Write_o    = 1'b0;
        IFID_Write_o  = 1'b0;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        if (rst_i && !mem_stall_o) begin
            if (load_use) begin
                IDEX_Bubble_o = 1'b1;
            end else begin
                PC_Write_o   = 1'b1;
                IFID_Write_o = 1'b1;
                IFID_Flush_o = Branch_taken_i || flush_pending;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state         <= RUN;
            flush_pending <= 1'b0;
            stall_cnt_o   <= 16'd0;
            hazard_cnt_o  <= 16'd0;
        end else begin
            state <= state_next;
            // Remember a branch taken under a memory freeze so its flush is issued later.
            if (IFID_Flush_o) begin
                flush_pending <= 1'b0;
            end else if (Branch_taken_i && mem_stall_o) begin
                flush_pending <= 1'b1;
            end
            if (cnt_clr_i) begin
                stall_cnt_o  <= 16'd0;
                hazard_cnt_o <= 16'd0;
            end else begin
                if (mem_stall_o && (stall_cnt_o != 16'hFFFF)) begin
                    stall_cnt_o <= stall_cnt_o + 16'd1;
                end
                if (IDEX_Bubble_o && (hazard_cnt_o != 16'hFFFF)) begin
                    hazard_cnt_o <= hazard_cnt_o + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: clk_i  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL: rst_i  in  1  synchronous active-low reset, sampled on the rising edge of clk_i.
REQ-003 SHALL: IDEX_MemRead_i  in  1  instruction in EX is a load.
REQ-004 SHALL: IDEX_Rd_i  in  5  destination register of the EX instruction.
REQ-005 SHALL: IFID_Rs1_i, IFID_Rs2_i  in  5 each  source registers of the ID instruction.
REQ-006 SHALL: Branch_taken_i  in  1  the ID-stage branch or jump resolves taken.
REQ-007 SHALL: dmem_req_i  in  1  the MEM stage issues a data-cache access this cycle.
REQ-008 SHALL: dmem_ack_i  in  1  the data cache completes the access this cycle (same cycle as dmem_req_i means hit).
REQ-009 SHALL: cnt_clr_i  in  1  synchronous clear of both performance counters.
REQ-010 SHALL: PC_Write_o  out  1  PC register load enable.
REQ-011 SHALL: IFID_Write_o  out  1  IF/ID pipeline register load enable.
REQ-012 SHALL: IFID_Flush_o  out  1  zero the IF/ID pipeline register.
REQ-013 SHALL: IDEX_Bubble_o  out  1  insert a NOP into ID/EX.
REQ-014 SHALL: mem_stall_o  out  1  freeze all pipeline registers and the PC.
REQ-015 SHALL: stall_cnt_o  out  16  count of memory-stall cycles.
REQ-016 SHALL: hazard_cnt_o  out  16  count of load-use bubble cycles.

Function
REQ-017 SHALL: use a 2-state FSM: RUN and MEM_WAIT.
REQ-018 SHALL: transition RUN->MEM_WAIT when dmem_req_i=1 and dmem_ack_i=0; transition MEM_WAIT->RUN when dmem_ack_i=1; hold state otherwise.
REQ-019 SHALL: drive mem_stall_o combinationally as (RUN and dmem_req_i and not dmem_ack_i) or (MEM_WAIT and not dmem_ack_i); a hit therefore adds 0 stall cycles, and the ack cycle itself does not stall.
REQ-020 SHALL: compute load-use hazard as IDEX_MemRead_i=1, IDEX_Rd_i!=0, and IDEX_Rd_i equal to IFID_Rs1_i or IFID_Rs2_i.
REQ-021 SHALL: apply the following priority, highest first:
  - mem_stall_o=1: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=0, IFID_Flush_o=0.
  - hazard: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, IFID_Flush_o=0.
  - otherwise: PC_Write_o=1, IFID_Write_o=1, IDEX_Bubble_o=0, IFID_Flush_o=(Branch_taken_i or flush_pending).
REQ-022 SHALL: set the flush_pending register when Branch_taken_i=1 and mem_stall_o=1; clear it on the first cycle in which IFID_Flush_o=1 is issued.
REQ-023 SHALL: not lose a taken branch that coincides with a memory stall; the flush SHALL be issued exactly once, on the first non-stall, non-hazard cycle.
REQ-024 SHALL: increment stall_cnt_o on every cycle with mem_stall_o=1, and increment hazard_cnt_o on every cycle with IDEX_Bubble_o=1.
REQ-025 SHALL: saturate both counters at 16'hFFFF, with no wrap.
REQ-026 SHALL: zero both counters on cnt_clr_i=1; clear wins over a simultaneous increment.
REQ-027 SHALL: allow dmem_ack_i=1 without dmem_req_i=1 in RUN; it SHALL be ignored and SHALL cause no state change.

Reset
REQ-028 SHALL: on rst_i=0 at a rising edge, set state to RUN, flush_pending to 0, stall_cnt_o to 0, and hazard_cnt_o to 0.
REQ-029 SHALL: force PC_Write_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_Bubble_o=0, and mem_stall_o=0 combinationally while rst_i=0.
REQ-030 SHALL: on reset asserted while in MEM_WAIT, abandon the pending access; on the first cycle after release, the block is in RUN and a late dmem_ack_i is ignored.

Verification
REQ-031 SHALL: hit: dmem_req_i=1 and dmem_ack_i=1 in one cycle -> mem_stall_o=0, state remains RUN, stall_cnt_o unchanged.
REQ-032 SHALL: miss: dmem_req_i=1, with dmem_ack_i rising 3 cycles later -> mem_stall_o=1 for exactly 3 cycles, then 0, and stall_cnt_o=3.
REQ-033 SHALL: load-use: IDEX_MemRead_i=1, IDEX_Rd_i=5, IFID_Rs2_i=5 -> IDEX_Bubble_o=1, PC_Write_o=0, and hazard_cnt_o increments by 1; the same stimulus with IDEX_Rd_i=0 -> no bubble.
REQ-034 SHALL: branch during stall: Branch_taken_i=1 pulsed in the 2nd stall cycle of a 4-cycle miss -> IFID_Flush_o=1 for exactly one cycle, on the ack cycle.
REQ-035 SHALL: saturation and clear: preload stall_cnt_o to 16'hFFFE, then run 3 stall cycles -> stall_cnt_o=16'hFFFF; asserting cnt_clr_i with a stall active -> stall_cnt_o=0.
REQ-036 SHALL: reset mid-miss: rst_i=0 in MEM_WAIT, then release, then dmem_ack_i=1 -> mem_stall_o=0, state RUN, counters 0.
